// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: word width and FSM state encoding.
package loader_pkg;

  localparam int INSTR_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } loaderState_e;

endpackage

// File: rtl/loader_mem.sv
// Program store for the instruction loader: synchronous write, asynchronous read.
module loader_mem
  import loader_pkg::*;
#(
  parameter int D = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [D-1:0]       wrAddr,
  input  logic [INSTR_W-1:0] wrData,
  input  logic [D-1:0]       rdAddr,
  output logic [INSTR_W-1:0] rdData
);

  // Contents are deliberately never reset; the loader masks words beyond the loaded length.
  logic [INSTR_W-1:0] mem [2**D];

  always_ff @(posedge clk) begin
    if (we) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/instr_loader.sv
// Streams a program into the store and holds the core in reset until it is complete.
// Optional XOR checksum of accepted words is enabled by defining LOADER_CHECKSUM_EN.
module instr_loader
  import loader_pkg::*;
#(
  parameter int D = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               reload,
  input  logic [D-1:0]       pc_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               core_reset,
  output logic [D:0]         loaded_count,
  output logic               overflow,
  output logic [INSTR_W-1:0] csum
);

  localparam logic [D:0] COUNT_ONE = {{D{1'b0}}, 1'b1};

  loaderState_e       stateQ, stateNext;
  logic [D:0]         loadedCount;
  logic               overflowQ;
  logic               accept;
  logic               atTop;
  logic [INSTR_W-1:0] memData;

  // A word arriving together with reload is dropped.
  assign accept = load_valid && load_ready && !reload;
  assign atTop  = (loadedCount[D-1:0] == {D{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateNext;
  end

  always_comb begin
    stateNext  = stateQ;
    load_ready = 1'b0;
    core_reset = 1'b1;
    unique case (stateQ)
      IDLE, LOAD: begin
        load_ready = 1'b1;
        if (accept) begin
          if (load_last)  stateNext = DONE;
          else if (atTop) stateNext = ERR;
          else            stateNext = LOAD;
        end
      end
      DONE:    core_reset = 1'b0;
      ERR:     ;
      default: stateNext = IDLE;
    endcase
    if (reload) stateNext = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loadedCount <= '0;
      overflowQ   <= 1'b0;
    end else if (reload) begin
      loadedCount <= '0;
      overflowQ   <= 1'b0;
    end else if (accept) begin
      loadedCount <= loadedCount + COUNT_ONE;
      if (atTop && !load_last) overflowQ <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] csumQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       csumQ <= '0;
    else if (reload) csumQ <= '0;
    else if (accept) csumQ <= csumQ ^ load_data;
  end

  assign csum = csumQ;
`else
  assign csum = '0;
`endif

  loader_mem #(.D(D)) uMem (
    .clk    (clk),
    .we     (accept),
    .wrAddr (loadedCount[D-1:0]),
    .wrData (load_data),
    .rdAddr (pc_addr),
    .rdData (memData)
  );

  assign instr        = ({1'b0, pc_addr} < loadedCount) ? memData : '0;
  assign loaded_count = loadedCount;
  assign overflow     = overflowQ;

endmodule
